// File: rtl/rx_core_cfg_sequencer_pkg.sv
// Shared types, address map and gain-step helper for the rx_core
// configuration sequencer.
package rx_cfg_pkg;

  localparam int CFG_ADDR_W = 4;
  localparam int CFG_DATA_W = 16;
  localparam int GAIN_W     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    APPLY     = 2'd2,
    RAMP      = 2'd3
  } state_t;

  localparam logic [CFG_ADDR_W-1:0] ADDR_DDC_PINC   = 4'd0;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DEMIX_GAIN = 4'd1;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DEMIX_PINC = 4'd2;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DUC1_PINC  = 4'd3;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DUC2_PINC  = 4'd4;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DUC3_PINC  = 4'd5;
  localparam logic [CFG_ADDR_W-1:0] ADDR_GAIN_DUC1  = 4'd6;
  localparam logic [CFG_ADDR_W-1:0] ADDR_GAIN_DUC2  = 4'd7;
  localparam logic [CFG_ADDR_W-1:0] ADDR_GAIN_DUC3  = 4'd8;

  // Move live toward target by at most step; the 9-bit difference keeps it wrap-free.
  function automatic logic [GAIN_W-1:0] gain_step_toward(
    input logic [GAIN_W-1:0] live,
    input logic [GAIN_W-1:0] target,
    input logic [GAIN_W-1:0] step
  );
    logic [GAIN_W:0]   diff;
    logic [GAIN_W-1:0] mag;
    logic [GAIN_W-1:0] mv;
    logic [GAIN_W-1:0] result;
    diff = {1'b0, target} - {1'b0, live};
    if (diff[GAIN_W]) begin
      mag = live - target;
    end else begin
      mag = diff[GAIN_W-1:0];
    end
    mv = (mag < step) ? mag : step;
    if (diff[GAIN_W]) begin
      result = live - mv;
    end else begin
      result = live + mv;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_core_cfg_sequencer_if.sv
// Configuration write/commit port of the rx_core configuration sequencer.
interface rx_core_cfg_sequencer_if;
  import rx_cfg_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [CFG_DATA_W-1:0] cfg_data;
  logic                  commit;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, commit,
    output cfg_ready
  );

endinterface

// File: rtl/rx_core_cfg_sequencer_gain_ramp.sv
// One DUC gain: steps its live value toward the target when enabled.
module gain_ramp
  import rx_cfg_pkg::*;
#(
  parameter int GAIN_STEP = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [GAIN_W-1:0] target,
  input  logic              step_en,
  output logic [GAIN_W-1:0] gain,
  output logic              at_target
);

  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(GAIN_STEP);

  logic [GAIN_W-1:0] gain_r;

  // Live gain register, moved one bounded step per enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gain_r <= {GAIN_W{1'b0}};
    end else if (step_en) begin
      gain_r <= gain_step_toward(gain_r, target, STEP);
    end
  end

  assign gain      = gain_r;
  assign at_target = (gain_r == target);

endmodule

// File: rtl/rx_core_cfg_sequencer.sv
// Shadow/live configuration sequencer: writes collect in shadow registers and
// a commit applies them on a frame wrap, with DUC gains ramped afterwards.
module rx_core_cfg_sequencer
  import rx_cfg_pkg::*;
#(
  parameter int FRAME_LEN     = 64,
  parameter int GAIN_STEP     = 1,
  parameter int RAMP_INTERVAL = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  rx_core_cfg_sequencer_if.slave cfg,
  output logic                   busy,
  output logic                   apply_strobe,
  output logic                   addr_err,
  output logic [CFG_DATA_W-1:0]  ddc_phase_inc,
  output logic [CFG_DATA_W-1:0]  demix_gain,
  output logic [CFG_DATA_W-1:0]  demix_phase_inc,
  output logic [CFG_DATA_W-1:0]  duc1_phase_inc,
  output logic [CFG_DATA_W-1:0]  duc2_phase_inc,
  output logic [CFG_DATA_W-1:0]  duc3_phase_inc,
  output logic [GAIN_W-1:0]      gain_duc1,
  output logic [GAIN_W-1:0]      gain_duc2,
  output logic [GAIN_W-1:0]      gain_duc3
);

  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int RAMP_W = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  FRAME_ONE  = CNT_W'(1);
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_INTERVAL - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE   = RAMP_W'(1);

  state_t                state_r;
  logic                  busy_r;
  logic                  strobe_r;
  logic                  pending_r;
  logic                  addr_err_r;
  logic [CNT_W-1:0]      frame_cnt_r;
  logic [RAMP_W-1:0]     ramp_cnt_r;
  logic [CFG_DATA_W-1:0] shadow_pinc_r [6];
  logic [GAIN_W-1:0]     shadow_gain_r [3];
  logic [CFG_DATA_W-1:0] live_pinc_r   [6];
  logic [GAIN_W-1:0]     target_r      [3];

  logic       cfg_ready_s;
  logic       wr_s;
  logic       frame_wrap_s;
  logic       step_en_s;
  logic       all_at_s;
  logic [2:0] at_target_s;

  assign cfg_ready_s   = (state_r == IDLE);
  assign cfg.cfg_ready = cfg_ready_s;
  assign wr_s          = cfg.cfg_valid && cfg_ready_s;
  assign frame_wrap_s  = (frame_cnt_r == FRAME_LAST);
  assign all_at_s      = &at_target_s;
  assign step_en_s     = (state_r == RAMP) && !all_at_s && (ramp_cnt_r == RAMP_LAST);

  // Free-running frame counter; the FSM never stalls it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else if (frame_wrap_s) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else begin
      frame_cnt_r <= frame_cnt_r + FRAME_ONE;
    end
  end

  // Shadow register file and sticky unmapped-address flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) shadow_pinc_r[i] <= {CFG_DATA_W{1'b0}};
      for (int i = 0; i < 3; i++) shadow_gain_r[i] <= {GAIN_W{1'b0}};
      addr_err_r <= 1'b0;
    end else if (wr_s) begin
      case (cfg.cfg_addr)
        ADDR_DDC_PINC:   shadow_pinc_r[0] <= cfg.cfg_data;
        ADDR_DEMIX_GAIN: shadow_pinc_r[1] <= cfg.cfg_data;
        ADDR_DEMIX_PINC: shadow_pinc_r[2] <= cfg.cfg_data;
        ADDR_DUC1_PINC:  shadow_pinc_r[3] <= cfg.cfg_data;
        ADDR_DUC2_PINC:  shadow_pinc_r[4] <= cfg.cfg_data;
        ADDR_DUC3_PINC:  shadow_pinc_r[5] <= cfg.cfg_data;
        ADDR_GAIN_DUC1:  shadow_gain_r[0] <= cfg.cfg_data[GAIN_W-1:0];
        ADDR_GAIN_DUC2:  shadow_gain_r[1] <= cfg.cfg_data[GAIN_W-1:0];
        ADDR_GAIN_DUC3:  shadow_gain_r[2] <= cfg.cfg_data[GAIN_W-1:0];
        default:         addr_err_r       <= 1'b1;
      endcase
    end
  end

  // Sequencing FSM with live phase registers, gain targets and ramp pacing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      strobe_r   <= 1'b0;
      pending_r  <= 1'b0;
      ramp_cnt_r <= {RAMP_W{1'b0}};
      for (int i = 0; i < 6; i++) live_pinc_r[i] <= {CFG_DATA_W{1'b0}};
      for (int i = 0; i < 3; i++) target_r[i] <= {GAIN_W{1'b0}};
    end else begin
      strobe_r <= 1'b0;
      // Commits arriving while busy collapse into a single pending request.
      if ((state_r != IDLE) && cfg.commit) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (cfg.commit || pending_r) begin
            state_r   <= WAIT_SYNC;
            busy_r    <= 1'b1;
            pending_r <= 1'b0;
          end
        end
        WAIT_SYNC: begin
          if (frame_wrap_s) begin
            state_r  <= APPLY;
            strobe_r <= 1'b1;
            for (int i = 0; i < 6; i++) live_pinc_r[i] <= shadow_pinc_r[i];
            for (int i = 0; i < 3; i++) target_r[i] <= shadow_gain_r[i];
          end
        end
        APPLY: begin
          state_r    <= RAMP;
          ramp_cnt_r <= {RAMP_W{1'b0}};
        end
        RAMP: begin
          if (all_at_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (ramp_cnt_r == RAMP_LAST) begin
            ramp_cnt_r <= {RAMP_W{1'b0}};
          end else begin
            ramp_cnt_r <= ramp_cnt_r + RAMP_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  gain_ramp #(.GAIN_STEP(GAIN_STEP)) u_ramp_duc1 (
    .clock(clock), .reset(reset), .target(target_r[0]), .step_en(step_en_s),
    .gain(gain_duc1), .at_target(at_target_s[0])
  );
  gain_ramp #(.GAIN_STEP(GAIN_STEP)) u_ramp_duc2 (
    .clock(clock), .reset(reset), .target(target_r[1]), .step_en(step_en_s),
    .gain(gain_duc2), .at_target(at_target_s[1])
  );
  gain_ramp #(.GAIN_STEP(GAIN_STEP)) u_ramp_duc3 (
    .clock(clock), .reset(reset), .target(target_r[2]), .step_en(step_en_s),
    .gain(gain_duc3), .at_target(at_target_s[2])
  );

  assign busy            = busy_r;
  assign apply_strobe    = strobe_r;
  assign addr_err        = addr_err_r;
  assign ddc_phase_inc   = live_pinc_r[0];
  assign demix_gain      = live_pinc_r[1];
  assign demix_phase_inc = live_pinc_r[2];
  assign duc1_phase_inc  = live_pinc_r[3];
  assign duc2_phase_inc  = live_pinc_r[4];
  assign duc3_phase_inc  = live_pinc_r[5];

endmodule

// File: tb/tb_rx_core_cfg_sequencer.sv
// Bench for rx_core_cfg_sequencer: a closed-form timing model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_rx_core_cfg_sequencer;

  localparam int FL = 64;
  localparam int GS = 3;
  localparam int RI = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rx_core_cfg_sequencer_if cfg_if ();

  logic        busy, apply_strobe, addr_err;
  logic [15:0] ddc_phase_inc, demix_gain, demix_phase_inc;
  logic [15:0] duc1_phase_inc, duc2_phase_inc, duc3_phase_inc;
  logic [7:0]  gain_duc1, gain_duc2, gain_duc3;

  rx_core_cfg_sequencer #(.FRAME_LEN(FL), .GAIN_STEP(GS), .RAMP_INTERVAL(RI)) dut (
    .clock(clock), .reset(reset), .cfg(cfg_if.slave),
    .busy(busy), .apply_strobe(apply_strobe), .addr_err(addr_err),
    .ddc_phase_inc(ddc_phase_inc), .demix_gain(demix_gain),
    .demix_phase_inc(demix_phase_inc), .duc1_phase_inc(duc1_phase_inc),
    .duc2_phase_inc(duc2_phase_inc), .duc3_phase_inc(duc3_phase_inc),
    .gain_duc1(gain_duc1), .gain_duc2(gain_duc2), .gain_duc3(gain_duc3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL timeout_%s: no event after %0d cycles, expected event", name, waited);
  endtask

  // Model: cycle index since reset release; events are computed in closed form at commit time.
  int          cyc;
  int          accept_c, idle_from, apply_at;
  bit          pending, m_err, model_ok = 1'b0;
  logic [15:0] sh_ph [6];
  logic [15:0] pend_ph [6];
  logic [15:0] m_ph [6];
  logic [7:0]  sh_g [3];
  int          g_start [3];
  int          g_tgt [3];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit m_ready(input int c);
    return !(c > accept_c && c < idle_from);
  endfunction

  function automatic int m_gain(input int c, input int i);
    int d, n, mv;
    if (c <= apply_at) return g_start[i];
    d  = g_tgt[i] - g_start[i];
    n  = (c - apply_at - 1) / RI;
    mv = GS * n;
    if (mv > iabs(d)) mv = iabs(d);
    return (d < 0) ? g_start[i] - mv : g_start[i] + mv;
  endfunction

  task automatic model_init();
    cyc = 0; accept_c = -1; idle_from = 0; apply_at = -1000;
    pending = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 6; i++) begin sh_ph[i] = 16'h0; pend_ph[i] = 16'h0; m_ph[i] = 16'h0; end
    for (int i = 0; i < 3; i++) begin sh_g[i] = 8'h0; g_start[i] = 0; g_tgt[i] = 0; end
  endtask

  always @(posedge clock) begin
    bit rdy;
    int a, nmax, d;
    if (reset) begin
      model_init();
      model_ok = 1'b1;
    end else if (model_ok) begin
      rdy = m_ready(cyc);
      a   = int'(cfg_if.cfg_addr);
      if (rdy && cfg_if.cfg_valid) begin
        if (a < 6) sh_ph[a] = cfg_if.cfg_data;
        else if (a < 9) sh_g[a-6] = cfg_if.cfg_data[7:0];
        else m_err = 1'b1;
      end
      if (rdy && (cfg_if.commit || pending)) begin
        pending  = 1'b0;
        accept_c = cyc;
        apply_at = ((cyc + 2 + FL - 1) / FL) * FL;
        nmax     = 0;
        for (int i = 0; i < 6; i++) pend_ph[i] = sh_ph[i];
        for (int i = 0; i < 3; i++) begin
          g_start[i] = g_tgt[i];
          g_tgt[i]   = int'(sh_g[i]);
          d = iabs(g_tgt[i] - g_start[i]);
          if ((d + GS - 1) / GS > nmax) nmax = (d + GS - 1) / GS;
        end
        idle_from = apply_at + nmax * RI + 2;
      end else if (!rdy && cfg_if.commit) begin
        pending = 1'b1;
      end
      cyc++;
      if (cyc == apply_at) for (int i = 0; i < 6; i++) m_ph[i] = pend_ph[i];
    end
  end

  always @(negedge clock) begin
    if (!reset && model_ok) begin
      check("cfg_ready", cfg_if.cfg_ready, m_ready(cyc));
      check("busy", busy, (cyc > accept_c && cyc < idle_from));
      check("apply_strobe", apply_strobe, (cyc == apply_at));
      check("addr_err", addr_err, m_err);
      check("ddc_phase_inc", ddc_phase_inc, m_ph[0]);
      check("demix_gain", demix_gain, m_ph[1]);
      check("demix_phase_inc", demix_phase_inc, m_ph[2]);
      check("duc1_phase_inc", duc1_phase_inc, m_ph[3]);
      check("duc2_phase_inc", duc2_phase_inc, m_ph[4]);
      check("duc3_phase_inc", duc3_phase_inc, m_ph[5]);
      check("gain_duc1", gain_duc1, m_gain(cyc, 0));
      check("gain_duc2", gain_duc2, m_gain(cyc, 1));
      check("gain_duc3", gain_duc3, m_gain(cyc, 2));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_data = d;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_if.commit = 1'b1;
    tick();
    cfg_if.commit = 1'b0;
  endtask

  task automatic wait_cnt(input int n);
    int k = 0;
    while ((cyc % FL) != n && k < 2 * FL) begin tick(); k++; end
    if (k >= 2 * FL) timeout_fail("frame_count", k);
  endtask

  task automatic wait_until(input int target);
    int k = 0;
    while (cyc < target && k < 1000) begin tick(); k++; end
    if (cyc != target) timeout_fail("cycle", k);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 1000) begin tick(); k++; end
    if (k >= 1000) timeout_fail("idle", k);
  endtask

  task automatic wait_strobe(output int t);
    int k = 0;
    while (apply_strobe !== 1'b1 && k < 3 * FL) begin tick(); k++; end
    if (k >= 3 * FL) timeout_fail("apply_strobe", k);
    t = cyc;
  endtask

  int c, t0, nstrobe;
  int offs [5] = '{4, 5, 9, 13, 17};
  int gexp [5] = '{0, 3, 6, 9, 10};

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = 4'd0;
    cfg_if.cfg_data = 16'h0; cfg_if.commit = 1'b0;
    repeat (2) tick();
    check("rst_ready", cfg_if.cfg_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ddc", ddc_phase_inc, 16'h0);
    reset = 1'b0;

    // Phase commit at counter 10 lands 54 cycles later.
    wr(4'd0, 16'h1234);
    wait_cnt(10);
    c = cyc;
    pulse_commit();
    wait_until(c + 53);
    check("pc_before_val", ddc_phase_inc, 16'h0);
    check("pc_before_strobe", apply_strobe, 1'b0);
    wait_until(c + 54);
    check("pc_val", ddc_phase_inc, 16'h1234);
    check("pc_strobe", apply_strobe, 1'b1);

    // Gain ramp 0 -> 10 in steps of 3.
    wait_idle();
    wr(4'd6, 16'd10);
    pulse_commit();
    wait_strobe(t0);
    for (int i = 0; i < 5; i++) begin
      wait_until(t0 + offs[i]);
      check("ramp_gain_duc1", gain_duc1, gexp[i]);
    end
    check("ramp_busy_last", busy, 1'b1);
    wait_until(t0 + 18);
    check("ramp_busy_fall", busy, 1'b0);

    // Unmapped write, then the upper data bits of a gain write are dropped.
    wr(4'd12, 16'hFFFF);
    check("unmapped_err", addr_err, 1'b1);
    wr(4'd7, 16'hABCD);
    pulse_commit();
    wait_idle();
    check("gain_duc2_cd", gain_duc2, 8'hCD);
    check("unmapped_ddc", ddc_phase_inc, 16'h1234);

    // Two commits during the ramp collapse into one more apply.
    wr(4'd1, 16'h5555);
    wr(4'd6, 16'd20);
    pulse_commit();
    wait_strobe(t0);
    nstrobe = 1;
    check("busy_demix", demix_gain, 16'h5555);
    wait_until(t0 + 3);
    pulse_commit();
    wait_until(t0 + 6);
    pulse_commit();
    while (cyc < t0 + 150) begin
      tick();
      if (apply_strobe === 1'b1) nstrobe++;
      if (cyc == t0 + 64) check("second_apply", apply_strobe, 1'b1);
    end
    check("strobe_count", nstrobe, 2);

    // Write and commit together at the last counter value: next wrap is missed.
    wait_idle();
    wait_cnt(FL - 1);
    c = cyc;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 4'd3; cfg_if.cfg_data = 16'h0BEE;
    cfg_if.commit = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; cfg_if.commit = 1'b0;
    wait_until(c + 64);
    check("coll_before", duc1_phase_inc, 16'h0);
    wait_until(c + 65);
    check("coll_val", duc1_phase_inc, 16'h0BEE);
    check("coll_strobe", apply_strobe, 1'b1);

    // Saturating approach to 255 and a downward ramp.
    wait_idle();
    wr(4'd8, 16'd250);
    pulse_commit();
    wait_idle();
    check("g3_250", gain_duc3, 8'd250);
    wr(4'd8, 16'd255);
    wr(4'd6, 16'd5);
    pulse_commit();
    wait_strobe(t0);
    wait_until(t0 + 5);
    check("g3_253", gain_duc3, 8'd253);
    check("g1_down_17", gain_duc1, 8'd17);
    wait_until(t0 + 9);
    check("g3_255", gain_duc3, 8'd255);
    wait_until(t0 + 22);
    check("down_done_busy", busy, 1'b0);
    check("g1_5", gain_duc1, 8'd5);

    // Asynchronous reset in the middle of a ramp.
    wr(4'd7, 16'h0000);
    pulse_commit();
    wait_strobe(t0);
    wait_until(t0 + 6);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_ddc", ddc_phase_inc, 16'h0);
    check("arst_gain2", gain_duc2, 8'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_err", addr_err, 1'b0);
    check("arst_ready", cfg_if.cfg_ready, 1'b1);
    repeat (2) tick();
    reset = 1'b0;
    wr(4'd0, 16'h0042);
    pulse_commit();
    wait_strobe(t0);
    check("post_rst_ddc", ddc_phase_inc, 16'h0042);
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
